dbus_req_ctrl: RTL and testbench

DBUS_REQ_CTRL -- requirements
Module: dbus_req_ctrl

---
 rtl/dbus_req_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dbus_req_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_req_ctrl.sv
// Data-bus request controller: one access at a time, IDLE -> REQ -> RESP, with load extraction.
// Optional MISALIGN_CHECK_EN: misaligned accesses skip the bus and report out_misalign.
module dbus_req_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wd,
  input  logic [7:0]  in_strobe,
  input  logic [1:0]  in_msize,
  input  logic        in_is_load,
  input  logic        in_sign_ext,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        out_misalign
`endif
);

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  localparam logic [1:0] MSIZE8 = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, wd_q;
  logic [7:0]  strobe_q;
  logic [1:0]  size_q;
  logic        load_q, sext_q;
  logic        drop_q, drop_d;
  logic [63:0] rdata_q, rdata_d;
  logic        accept_c;
  logic [5:0]  shamt_c;
  logic [63:0] shifted_c, result_c;
  logic        misalign_c;
`ifdef MISALIGN_CHECK_EN
  logic        mis_q, mis_d;
`endif

  assign accept_c = in_valid && (state_q == IDLE) && !flush;

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    unique case (in_msize)
      MSIZE2:  misalign_c = in_addr[0];
      MSIZE4:  misalign_c = |in_addr[1:0];
      MSIZE8:  misalign_c = |in_addr[2:0];
      default: misalign_c = 1'b0;
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Lane select from the registered address, then sign/zero extend.
  always_comb begin
    shamt_c = 6'd0;
    unique case (size_q)
      MSIZE1:  shamt_c = {addr_q[2:0], 3'b000};
      MSIZE2:  shamt_c = {addr_q[2:1], 4'b0000};
      MSIZE4:  shamt_c = {addr_q[2], 5'b00000};
      default: shamt_c = 6'd0;
    endcase
    shifted_c = dresp_data >> shamt_c;
    unique case (size_q)
      MSIZE1:  result_c = {{56{sext_q & shifted_c[7]}}, shifted_c[7:0]};
      MSIZE2:  result_c = {{48{sext_q & shifted_c[15]}}, shifted_c[15:0]};
      MSIZE4:  result_c = {{32{sext_q & shifted_c[31]}}, shifted_c[31:0]};
      default: result_c = shifted_c;
    endcase
    if (!load_q) result_c = 64'd0;
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    rdata_d = rdata_q;
`ifdef MISALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (misalign_c) begin
            state_d = RESP;
            rdata_d = 64'd0;
          end else begin
            state_d = REQ;
          end
`ifdef MISALIGN_CHECK_EN
          mis_d = misalign_c;
`endif
        end
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (dresp_data_ok) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            rdata_d = result_c;
          end
        end
      end
      RESP: begin
        if (flush || out_ready) begin
          state_d = IDLE;
`ifdef MISALIGN_CHECK_EN
          mis_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      rdata_q  <= 64'd0;
      addr_q   <= 64'd0;
      wd_q     <= 64'd0;
      strobe_q <= 8'd0;
      size_q   <= MSIZE1;
      load_q   <= 1'b0;
      sext_q   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      rdata_q <= rdata_d;
`ifdef MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
      if (accept_c) begin
        addr_q   <= in_addr;
        wd_q     <= in_wd;
        strobe_q <= in_strobe;
        size_q   <= in_msize;
        load_q   <= in_is_load;
        sext_q   <= in_sign_ext;
      end
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign dreq_valid  = (state_q == REQ);
  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = strobe_q;
  assign dreq_data   = wd_q;
  assign out_valid   = (state_q == RESP);
  assign out_rdata   = rdata_q;
`ifdef MISALIGN_CHECK_EN
  assign out_misalign = mis_q;
`endif

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Bench for dbus_req_ctrl: directed scenarios plus randomized accesses against a byte-lane model.
module tb_dbus_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_addr, in_wd;
  logic [7:0]  in_strobe;
  logic [1:0]  in_msize;
  logic        in_is_load, in_sign_ext, flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid, out_ready;
  logic [63:0] out_rdata;
`ifdef MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dbus_req_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wd(in_wd), .in_strobe(in_strobe), .in_msize(in_msize),
    .in_is_load(in_is_load), .in_sign_ext(in_sign_ext), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata)
`ifdef MISALIGN_CHECK_EN
    , .out_misalign(out_misalign)
`endif
  );

  // Reference: pick the naturally aligned container of the access, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] sz,
                                           input logic sx, input logic [63:0] data);
    int nb, off;
    logic [63:0] v, mask;
    nb   = 1 << sz;
    off  = (int'(addr[2:0]) / nb) * nb;
    v    = data >> (8 * off);
    if (nb == 8) return v;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (sx && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_addr = 0; in_wd = 0; in_strobe = 0; in_msize = 0;
    in_is_load = 0; in_sign_ext = 0; flush = 0;
    dresp_data_ok = 0; dresp_data = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    if (in_ready !== 1'b1)    begin errs++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    vecs++;
    if (dreq_valid !== 1'b0)  begin errs++; $display("FAIL rst_dreq_valid got %b exp 0", dreq_valid); end
    vecs++;
    if ({dreq_addr, dreq_data, dreq_strobe} !== '0) begin
      errs++; $display("FAIL rst_dreq_fields got %h %h %h exp 0", dreq_addr, dreq_data, dreq_strobe);
    end
    vecs++;
    if (out_valid !== 1'b0 || out_rdata !== 64'd0) begin
      errs++; $display("FAIL rst_out got %b %h exp 0 0", out_valid, out_rdata);
    end
    vecs++;
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    in_valid = 1; in_addr = 64'h8000_0003; in_msize = 2'd0; in_is_load = 1; in_sign_ext = 1;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0003) begin
        errs++; $display("FAIL lb_req cyc%0d got %b %h exp 1 80000003", i, dreq_valid, dreq_addr);
      end
      dresp_data_ok = (i == 1); dresp_data = 64'h0000_0000_8000_0000;
      @(negedge clk);
    end
    dresp_data_ok = 0;
    vecs++;
    if (out_valid !== 1'b1 || out_rdata !== 64'hFFFF_FFFF_FFFF_FF80 || dreq_valid !== 1'b0) begin
      errs++; $display("FAIL lb_result got %b %h exp 1 ffffffffffffff80", out_valid, out_rdata);
    end
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask

  task automatic test_store_backpressure();
    in_valid = 1; in_addr = 64'h8000_0004; in_msize = 2'd2; in_is_load = 0; in_sign_ext = 0;
    in_strobe = 8'hF0; in_wd = 64'h1234_5678_0000_0000;
    @(negedge clk);
    in_valid = 0;
    vecs++;
    if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hF0 || dreq_data !== 64'h1234_5678_0000_0000) begin
      errs++; $display("FAIL sw_req got %b %h %h", dreq_valid, dreq_strobe, dreq_data);
    end
    dresp_data_ok = 1; dresp_data = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    dresp_data_ok = 0;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_rdata !== 64'd0 || in_ready !== 1'b0 || dreq_valid !== 1'b0) begin
        errs++; $display("FAIL sw_hold cyc%0d got v=%b d=%h rdy=%b", i, out_valid, out_rdata, in_ready);
      end
      if (i == 3) out_ready = 1;
      @(negedge clk);
    end
    out_ready = 0;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL sw_done got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    // Flush in IDLE blocks acceptance.
    in_valid = 1; flush = 1; in_addr = 64'h10; in_msize = 2'd3; in_is_load = 1;
    @(negedge clk);
    in_valid = 0; flush = 0;
    vecs++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL flush_idle got dv=%b rdy=%b exp 0 1", dreq_valid, in_ready);
    end
    // Flush in REQ cycle 1, data_ok in cycle 3.
    in_valid = 1; @(negedge clk); in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (dreq_valid !== 1'b1) begin errs++; $display("FAIL flush_req_hold cyc%0d got %b exp 1", i, dreq_valid); end
      flush = (i == 0); dresp_data_ok = (i == 2); dresp_data = 64'h55;
      @(negedge clk);
    end
    flush = 0; dresp_data_ok = 0;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL flush_req_drop got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    // Flush together with data_ok.
    in_valid = 1; @(negedge clk); in_valid = 0;
    flush = 1; dresp_data_ok = 1; @(negedge clk); flush = 0; dresp_data_ok = 0;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dreq_valid !== 1'b0) begin
      errs++; $display("FAIL flush_same got v=%b rdy=%b dv=%b exp 0 1 0", out_valid, in_ready, dreq_valid);
    end
    // Flush in RESP kills the held result.
    in_valid = 1; @(negedge clk); in_valid = 0;
    dresp_data_ok = 1; @(negedge clk); dresp_data_ok = 0;
    vecs++;
    if (out_valid !== 1'b1) begin errs++; $display("FAIL flush_resp_pre got %b exp 1", out_valid); end
    flush = 1; @(negedge clk); flush = 0;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL flush_resp got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_req();
    in_valid = 1; in_addr = 64'h8; in_msize = 2'd3; in_is_load = 1;
    @(negedge clk);
    in_valid = 0;
    vecs++;
    if (dreq_valid !== 1'b1) begin errs++; $display("FAIL rmr_pre got %b exp 1", dreq_valid); end
    #1 reset = 1;
    #1;
    vecs++;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++; $display("FAIL rmr_async got dv=%b rdy=%b v=%b exp 0 1 0", dreq_valid, in_ready, out_valid);
    end
    @(negedge clk);
    reset = 0; dresp_data_ok = 1;
    @(negedge clk);
    dresp_data_ok = 0;
    vecs++;
    if (out_valid !== 1'b0 || dreq_valid !== 1'b0) begin
      errs++; $display("FAIL rmr_after got v=%b dv=%b exp 0 0", out_valid, dreq_valid);
    end
  endtask

`ifdef MISALIGN_CHECK_EN
  task automatic test_misalign();
    in_valid = 1; in_addr = 64'h8000_0002; in_msize = 2'd2; in_is_load = 1; in_sign_ext = 0;
    @(negedge clk);
    in_valid = 0;
    vecs++;
    if (dreq_valid !== 1'b0 || out_valid !== 1'b1 || out_misalign !== 1'b1 || out_rdata !== 64'd0) begin
      errs++; $display("FAIL misalign got dv=%b v=%b m=%b d=%h", dreq_valid, out_valid, out_misalign, out_rdata);
    end
    out_ready = 1; @(negedge clk); out_ready = 0;
  endtask
`endif

  task automatic test_random();
    logic [63:0] a, wd, rsp, exp;
    logic [1:0]  sz;
    logic [7:0]  strb;
    logic        ld, sx, mis;
    int          lat, bp, nb;
    for (int t = 0; t < 60; t++) begin
      a   = {$urandom, $urandom};
      sz  = 2'($urandom_range(0, 3));
      ld  = 1'($urandom_range(0, 1));
      sx  = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      nb  = 1 << sz;
      strb = ld ? 8'h00 : 8'((((1 << nb) - 1) << ((int'(a[2:0]) / nb) * nb)) & 8'hFF);
      lat = $urandom_range(1, 3);
      bp  = $urandom_range(0, 2);
      mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
      mis = (int'(a[2:0]) % nb) != 0;
`endif
      rsp = 64'd0;
      in_valid = 1; in_addr = a; in_msize = sz; in_is_load = ld; in_sign_ext = sx;
      in_wd = wd; in_strobe = strb;
      @(negedge clk);
      in_valid = 0;
      if (!mis) begin
        for (int i = 0; i < lat; i++) begin
          vecs++;
          if (dreq_valid !== 1'b1 || dreq_addr !== a || dreq_size !== sz ||
              dreq_strobe !== strb || dreq_data !== wd) begin
            errs++;
            $display("FAIL rnd%0d_req got dv=%b a=%h sz=%0d s=%h d=%h exp a=%h s=%h d=%h",
                     t, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data, a, strb, wd);
          end
          dresp_data    = {$urandom, $urandom};
          rsp           = dresp_data;
          dresp_data_ok = (i == lat - 1);
          @(negedge clk);
        end
        dresp_data_ok = 0;
      end
      exp = (ld && !mis) ? ref_load(a, sz, sx, rsp) : 64'd0;
      for (int b = 0; b <= bp; b++) begin
        vecs++;
        if (out_valid !== 1'b1 || out_rdata !== exp || in_ready !== 1'b0 || dreq_valid !== 1'b0) begin
          errs++;
          $display("FAIL rnd%0d_out got v=%b d=%h rdy=%b exp 1 %h 0", t, out_valid, out_rdata, in_ready, exp);
        end
`ifdef MISALIGN_CHECK_EN
        vecs++;
        if (out_misalign !== mis) begin
          errs++; $display("FAIL rnd%0d_mis got %b exp %b", t, out_misalign, mis);
        end
`endif
        out_ready = (b == bp);
        @(negedge clk);
      end
      out_ready = 0;
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++; $display("FAIL rnd%0d_done got v=%b rdy=%b exp 0 1", t, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_backpressure();
    test_flush();
    test_reset_mid_req();
`ifdef MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
